// File: rtl/keypad_entry_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the keypad entry block: keypad geometry, digit
// count, the scan FSM state encoding, and the row/column to key-code mapping.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
  localparam int IDX_W  = 2;               // bits to index a row or a column
  localparam int DIGITS = 4;               // digits shown on the display path
  localparam int HEX_W  = DIGITS * CODE_W;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HOLD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Result of looking at one sampled column word.
  typedef struct packed {
    logic             one;   // exactly one column is pulled low
    logic [IDX_W-1:0] idx;   // index of the low column (valid when one = 1)
  } col_hit_t;

  // Key code = COLS*row + col, so row 0/col 0 is 0x0 and row 3/col 3 is 0xF.
  function automatic logic [CODE_W-1:0] key_code_of(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
    return CODE_W'(COLS * int'(row) + int'(col));
  endfunction

  // Several low columns in one row is a ghost/multi-press and is rejected.
  function automatic col_hit_t decode_cols(input logic [COLS-1:0] cols);
    col_hit_t h;
    int       lows;
    h    = '0;
    lows = 0;
    for (int c = 0; c < COLS; c++) begin
      if (!cols[c]) begin
        lows++;
        h.idx = IDX_W'(c);
      end
    end
    h.one = (lows == 1);
    return h;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// -----------------------------------------------------------------------------
// keypad_entry_if
// Output bundle from the keypad entry block toward the display path / host.
//   key_valid : one-cycle pulse per accepted key
//   key_code  : code of the last accepted key
//   hexs      : entered digits, newest in [3:0]
//   LEs       : per-digit blank, 1 = blank
// master = keypad_entry (drives), slave = consumer.
// -----------------------------------------------------------------------------
interface keypad_entry_if;
  import keypad_pkg::*;

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic [HEX_W-1:0]  hexs;
  logic [DIGITS-1:0] LEs;

  modport master (output key_valid, key_code, hexs, LEs);
  modport slave  (input  key_valid, key_code, hexs, LEs);
endinterface

// File: rtl/keypad_entry_stable_cnt.sv
// -----------------------------------------------------------------------------
// key_stable_cnt
// Counts consecutive cycles in which cond holds while en is high and flags hit
// on the N-th such cycle. Any cycle with en or cond low clears the count; the
// count also restarts after a hit, so a steady condition hits every N cycles.
//   clk, rst : clock, asynchronous active-low reset
//   en       : counter enabled (owning FSM state active)
//   cond     : condition being timed
//   hit      : combinational, high on the N-th consecutive qualifying cycle
// -----------------------------------------------------------------------------
module key_stable_cnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cond,
  output logic hit
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  assign hit = en && cond && (cnt == W'(N - 1));

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would make results order-dependent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (!en || !cond || hit)  cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// shifts accepted hex digits into a 16-bit value for the seven-segment path.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   col_in  : keypad columns, active-low, asynchronous (synchronized here)
//   clr     : synchronous clear of the entered value (active-high level)
//   row_out : active-low one-hot row drive
//   kp      : keypad_entry_if.master (key_valid, key_code, hexs, LEs)
// Build option: define KEY_REPEAT_EN to re-emit a held key every REPEAT_CNT
// cycles; without it a held key is accepted exactly once.
// -----------------------------------------------------------------------------
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 250000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_in,
  input  logic            clr,
  output logic [ROWS-1:0] row_out,
  keypad_entry_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [COLS-1:0]   col_s1, col_s;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  row_q;
  logic [DIV_W-1:0]  div_q;
  logic [COLS-1:0]   pat_q;      // column pattern latched at detection
  logic [CODE_W-1:0] code_q;     // code latched at detection
  logic [2:0]        n_q;        // entered digit count, saturates at DIGITS
  col_hit_t          scan_hit;
  logic              row_done, row_adv;
  logic              press_hit, rel_hit, rep_hit, accept;

  // Two-flop synchronizer; idle (all high) out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= '1;
      col_s  <= '1;
    end else begin
      col_s1 <= col_in;
      col_s  <= col_s1;
    end
  end

  assign scan_hit = decode_cols(col_s);
  assign row_done = (div_q == DIV_W'(SCAN_DIV - 1));

  key_stable_cnt #(.N(DEBOUNCE_CNT)) u_press_db (
    .clk (clk), .rst (rst),
    .en  (state_q == PRESS_DB), .cond (col_s == pat_q), .hit (press_hit)
  );

  key_stable_cnt #(.N(DEBOUNCE_CNT)) u_rel_db (
    .clk (clk), .rst (rst),
    .en  (state_q == REL_DB), .cond (col_s == '1), .hit (rel_hit)
  );

`ifdef KEY_REPEAT_EN
  // Runs only while in HOLD, so it restarts from zero on every new hold.
  key_stable_cnt #(.N(REPEAT_CNT)) u_repeat (
    .clk (clk), .rst (rst),
    .en  (state_q == HOLD), .cond (1'b1), .hit (rep_hit)
  );
`else
  assign rep_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SCAN;
    else      state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    row_adv = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (row_done) begin
          if (scan_hit.one) state_d = PRESS_DB;
          else              row_adv = 1'b1;
        end
      end
      PRESS_DB: begin
        if (col_s != pat_q) begin
          state_d = SCAN;
          row_adv = 1'b1;
        end else if (press_hit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (col_s == '1) state_d = REL_DB;
      end
      REL_DB: begin
        if (col_s != '1) begin
          state_d = HOLD;
        end else if (rel_hit) begin
          state_d = SCAN;
          row_adv = 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Output logic.
  always_comb begin
    row_out        = '1;
    row_out[row_q] = 1'b0;
    accept         = press_hit || rep_hit;
    kp.LEs         = '1;
    for (int i = 0; i < DIGITS; i++) kp.LEs[i] = (3'(i) >= n_q);
  end

  // Row scan counters and the key latched at detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      div_q  <= '0;
      pat_q  <= '1;
      code_q <= '0;
    end else begin
      if (state_q == SCAN && row_done && scan_hit.one) begin
        pat_q  <= col_s;
        code_q <= key_code_of(row_q, scan_hit.idx);
      end
      if (row_adv) row_q <= row_q + 1'b1;
      // The divider only runs while scanning; a held row restarts at zero.
      if (state_q == SCAN && !row_done) div_q <= div_q + 1'b1;
      else                              div_q <= '0;
    end
  end

  // Accept actions. clr takes priority over the pulse and the shift, but the
  // code register still captures the key so key_code tracks the last press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kp.key_valid <= 1'b0;
      kp.key_code  <= '0;
      kp.hexs      <= '0;
      n_q          <= '0;
    end else begin
      kp.key_valid <= accept && !clr;
      if (accept) kp.key_code <= code_q;
      if (clr) begin
        kp.hexs <= '0;
        n_q     <= '0;
      end else if (accept) begin
        kp.hexs <= {kp.hexs[HEX_W-CODE_W-1:0], code_q};
        if (n_q != 3'(DIGITS)) n_q <= n_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry
// Self-checking bench for keypad_entry with SCAN_DIV=4, DEBOUNCE_CNT=8,
// REPEAT_CNT=20. A behavioural keypad drives col_in from row_out and the set
// of pressed keys. Table-driven entry sequence plus directed corner cases.
// -----------------------------------------------------------------------------
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CNT   = 20;

  typedef struct {
    bit          do_clr;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [3:0]  code;
    logic [15:0] hexs;
    logic [3:0]  les;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] keys = '0;   // physical key positions, bit = 4*row + col
  int          n_checks = 0;
  int          n_pass = 0;

  keypad_entry_if kif ();

  keypad_entry #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_CNT   (REPEAT_CNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .col_in  (col_in),
    .clr     (clr),
    .row_out (row_out),
    .kp      (kif.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
  end

  function automatic logic [15:0] key_bit(input logic [1:0] row, input logic [1:0] col);
    return 16'd1 << (4*int'(row) + int'(col));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_pulse(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid) seen = 1'b1;
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (kif.key_valid) cnt++;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check("clr_hexs", kif.hexs, 16'h0000);
    check("clr_les", kif.LEs, 4'b1111);
  endtask

  initial begin
    vec_t       vecs[9];
    bit         seen;
    bit         found;
    int         cnt, cnt2, kv_bad, out_bad;
    logic [3:0] exp_row, rows_seen;

    vecs[0] = '{1'b1, 2'd2, 2'd1, 4'h9, 16'h0009, 4'b1110};
    vecs[1] = '{1'b1, 2'd0, 2'd1, 4'h1, 16'h0001, 4'b1110};
    vecs[2] = '{1'b0, 2'd0, 2'd2, 4'h2, 16'h0012, 4'b1100};
    vecs[3] = '{1'b0, 2'd0, 2'd3, 4'h3, 16'h0123, 4'b1000};
    vecs[4] = '{1'b0, 2'd1, 2'd0, 4'h4, 16'h1234, 4'b0000};
    vecs[5] = '{1'b0, 2'd1, 2'd1, 4'h5, 16'h2345, 4'b0000};
    vecs[6] = '{1'b0, 2'd0, 2'd0, 4'h0, 16'h3450, 4'b0000};
    vecs[7] = '{1'b1, 2'd3, 2'd3, 4'hF, 16'h000F, 4'b1110};
    vecs[8] = '{1'b0, 2'd3, 2'd0, 4'hC, 16'h00FC, 4'b1100};

    // Reset values, then the idle row walk (row changes every SCAN_DIV cycles).
    repeat (3) @(negedge clk);
    check("rst_row", row_out, 4'b1110);
    check("rst_kv", kif.key_valid, 1'b0);
    check("rst_code", kif.key_code, 4'h0);
    check("rst_hexs", kif.hexs, 16'h0000);
    check("rst_les", kif.LEs, 4'b1111);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      exp_row = ~(4'b0001 << (i / 4));
      check($sformatf("walk_row%0d", i), row_out, exp_row);
      if (kif.key_valid) cnt++;
      @(negedge clk);
    end
    check("walk_no_kv", cnt, 0);
    check("walk_hexs", kif.hexs, 16'h0000);
    check("walk_les", kif.LEs, 4'b1111);

    // Table-driven entry: press, check accept outputs, hold, release.
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_clr) pulse_clr();
      keys = key_bit(vecs[v].row, vecs[v].col);
      wait_pulse(100, seen);
      check($sformatf("v%0d_kv", v), seen, 1'b1);
      check($sformatf("v%0d_code", v), kif.key_code, vecs[v].code);
      check($sformatf("v%0d_hexs", v), kif.hexs, vecs[v].hexs);
      check($sformatf("v%0d_les", v), kif.LEs, vecs[v].les);
      count_pulses(10, cnt);
      keys = '0;
      count_pulses(20, cnt2);
      check($sformatf("v%0d_single", v), cnt + cnt2, 0);
    end

    // Bounce: key 6 toggles every 3 cycles for 30 cycles, then stays pressed.
    pulse_clr();
    keys = key_bit(2'd1, 2'd2);
    cnt2 = 0;
    repeat (10) begin
      count_pulses(3, cnt);
      cnt2 += cnt;
      keys ^= key_bit(2'd1, 2'd2);
    end
    check("bounce_no_kv", cnt2, 0);
    wait_pulse(100, seen);
    check("bounce_kv", seen, 1'b1);
    check("bounce_code", kif.key_code, 4'h6);
    check("bounce_hexs", kif.hexs, 16'h0006);
    count_pulses(10, cnt);
    keys = '0;
    count_pulses(20, cnt2);
    check("bounce_single", cnt + cnt2, 0);

    // Ghost: two columns low in row 2 -> no acceptance, all rows keep scanning.
    keys = key_bit(2'd2, 2'd0) | key_bit(2'd2, 2'd1);
    rows_seen = '0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      rows_seen |= ~row_out;
      if (kif.key_valid) cnt++;
    end
    check("ghost_no_kv", cnt, 0);
    check("ghost_rows", rows_seen, 4'b1111);
    check("ghost_hexs", kif.hexs, 16'h0006);
    keys = '0;
    repeat (10) @(negedge clk);

    // clr held across an acceptance of key 0xE: clr wins, code still loads.
    clr  = 1'b1;
    keys = key_bit(2'd3, 2'd2);
    kv_bad  = 0;
    out_bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (kif.key_valid) kv_bad++;
      if (kif.hexs !== 16'h0000 || kif.LEs !== 4'b1111) out_bad++;
    end
    check("clrwin_no_kv", kv_bad, 0);
    check("clrwin_outs", out_bad, 0);
    check("clrwin_code", kif.key_code, 4'hE);
    clr  = 1'b0;
    keys = '0;
    count_pulses(20, cnt);
    check("clrwin_after_kv", cnt, 0);
    check("clrwin_after_hexs", kif.hexs, 16'h0000);

    // Held key 0xF for 70 cycles after acceptance.
    pulse_clr();
    keys = key_bit(2'd3, 2'd3);
    wait_pulse(100, seen);
    check("hold_kv", seen, 1'b1);
    count_pulses(70, cnt);
`ifdef KEY_REPEAT_EN
    check("hold_extra", cnt, 3);
    check("hold_hexs", kif.hexs, 16'hFFFF);
    check("hold_les", kif.LEs, 4'b0000);
`else
    check("hold_extra", cnt, 0);
    check("hold_hexs", kif.hexs, 16'h000F);
    check("hold_les", kif.LEs, 4'b1110);
`endif
    keys = '0;
    count_pulses(20, cnt);
    check("hold_rel_kv", cnt, 0);

    // Reset in the middle of PRESS_DB for key 7 (row 1, col 3).
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_out !== 4'b1101) found = 1'b1;
    end
    keys  = key_bit(2'd1, 2'd3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_out === 4'b1101) found = 1'b1;
    end
    check("rstmid_row_found", found, 1'b1);
    count_pulses(6, cnt);
    check("rstmid_no_kv", cnt, 0);
    check("rstmid_held_row", row_out, 4'b1101);
    rst = 1'b0;
    #1;
    check("rstmid_row", row_out, 4'b1110);
    check("rstmid_kv", kif.key_valid, 1'b0);
    check("rstmid_code", kif.key_code, 4'h0);
    check("rstmid_hexs", kif.hexs, 16'h0000);
    check("rstmid_les", kif.LEs, 4'b1111);
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_pulses(40, cnt);
    check("rstmid_discard_kv", cnt, 0);
    check("rstmid_discard_hexs", kif.hexs, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces presses, and assembles entered hex digits into a 16-bit value. It is the input-side counterpart of the 4-digit seven-segment display path. Its `hexs` and `LEs` outputs feed the display block directly, so typed digits appear right-aligned and unused digits stay blank.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles each row stays driven before columns are sampled; must be ≥ 4.
- DEBOUNCE_CNT, 250000: consecutive stable cycles required to accept a press or a release.
- REPEAT_CNT, 25000000: hold cycles between auto-repeat emissions; used only with KEY_REPEAT_EN.

Ports:
- clk, input, 1: system clock; single clock domain.
- rst, input, 1: reset, asynchronous, active-low.
- col_in, input, 4: keypad columns, active-low, externally pulled up, asynchronous.
- clr, input, 1: synchronous clear of the entered value; active-high, level.
- row_out, output, 4: row drive, active-low one-hot.
- key_valid, output, 1: one-cycle pulse per accepted key.
- key_code, output, 4: code of the last accepted key; held between pulses.
- hexs, output, 16: entered digits; newest digit in [3:0].
- LEs, output, 4: per-digit blank; 1 means blank, matching the display path.

## Operation
- col_in passes through a 2-flop synchronizer. All column decisions use the synchronized value (colS).
- Key code = 4*row + col. Row 0/col 0 = 0x0; row 3/col 3 = 0xF.
- FSM states:
  - SCAN
    - Row index r cycles 0→1→2→3→0. Each row is held SCAN_DIV cycles.
    - colS is sampled on the last cycle of each row period.
    - If exactly one colS bit is low, latch r and the column c, then go to PRESS_DB with the row held.
    - If zero or several bits are low, advance the row (ghost presses are ignored).
  - PRESS_DB
    - A counter increments while colS equals the latched pattern. Any mismatch returns to SCAN at the next row, with the counter cleared.
    - When the counter reaches DEBOUNCE_CNT-1, the key is accepted and the FSM goes to HOLD.
  - HOLD
    - Row stays held.
    - When colS = 4'b1111, go to REL_DB.
  - REL_DB
    - Count consecutive all-high cycles. Any low bit returns to HOLD.
    - When the count reaches DEBOUNCE_CNT-1, go to SCAN and advance to the next row.
- Accept actions, all in the same cycle:
  - key_valid pulses.
  - key_code is loaded.
  - hexs is updated to {hexs[11:0], code}.
  - digit count n increments, saturating at 4.
  - LEs[i] = 0 for i < n, else 1.
  - After more than 4 entries, the oldest digit is shifted out and LEs stays 4'b0000.
- clr:
  - When asserted, hexs = 0, n = 0, LEs = 4'b1111.
  - The FSM is not affected.
  - If clr and an acceptance fall in the same cycle, clr wins: no key_valid pulse, hexs is not shifted, key_code is still loaded.
- rst low at any time: all state returns to reset immediately. A half-debounced key is discarded.

## Timing
- Reset values:
  - row_out = 4'b1110
  - key_valid = 0
  - key_code = 0
  - hexs = 0
  - LEs = 4'b1111
  - FSM = SCAN, row counter = 0, debounce/divider counters = 0
- Input latency: 2 cycles through the synchronizer.
- Acceptance: key_valid rises DEBOUNCE_CNT cycles after entering PRESS_DB. hexs, LEs and key_code change on that same clock edge.
- Minimum time from a stable press until key_valid: one row sample, plus DEBOUNCE_CNT, plus 2.
- Exactly one key_valid per press, except when auto-repeat is enabled.

## Configuration
- KEY_REPEAT_EN defined:
  - In HOLD, a repeat counter runs.
  - Each time it reaches REPEAT_CNT-1, the accept actions repeat with the same code, and the counter restarts.
  - The counter clears on leaving HOLD.
- KEY_REPEAT_EN undefined:
  - No repeat counter exists.
  - A held key produces exactly one acceptance.

## Structure
- Package keypad_pkg holds:
  - FSM state enum (SCAN, PRESS_DB, HOLD, REL_DB)
  - ROWS = 4, COLS = 4, CODE_W = 4
  - the code-mapping function
- One sub-module, key_stable_cnt: a parameterized counter that flags "condition held N cycles" and clears on mismatch. It is instantiated for press and release debounce.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=20.
- Reset release, no key pressed → row_out walks 1110, 1101, 1011, 0111 every 4 cycles. hexs = 0, LEs = 1111, key_valid never pulses.
- Press row 2/col 1 cleanly → exactly one key_valid, key_code = 0x9, hexs = 0x0009, LEs = 1110. No further pulse until release plus 8 cycles.
- Enter 1, 2, 3, 4, 5 → hexs = 0x2345, LEs = 0000.
- Bounce: col toggles every 3 cycles for 30 cycles, then stable → no pulse during the bounce, one pulse after 8 stable cycles.
- Two columns low in the same row → no acceptance, scan continues. Assert clr in the same cycle as an acceptance → hexs = 0, LEs = 1111, no key_valid.
- KEY_REPEAT_EN defined, key 0xF held for 70 cycles after acceptance → 3 extra key_valid pulses, hexs = 0xFFFF. rst asserted mid-PRESS_DB → all outputs at reset values immediately.
